// File: rtl/timerio_pkg.sv
// Shared register map and control-bit layout for the timerio peripheral.
package timerio_pkg;

   localparam logic [2:0] A_CTRL     = 3'd0;
   localparam logic [2:0] A_STAT     = 3'd1;
   localparam logic [2:0] A_PRESC    = 3'd2;
   localparam logic [2:0] A_RELOAD_H = 3'd3;
   localparam logic [2:0] A_RELOAD_L = 3'd4;
   localparam logic [2:0] A_COUNT_H  = 3'd5;
   localparam logic [2:0] A_COUNT_L  = 3'd6;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_MODE = 1;
   localparam int CTRL_IE   = 2;

   // Field order matches CTRL bits [2:0] so a raw byte slice maps straight in.
   typedef struct packed {
      logic ie;
      logic mode;
      logic en;
   } ctrl_t;

endpackage

// File: rtl/timerio_if.sv
// CPU-side bus of the timerio peripheral: register select, data, strobes and irq.
interface timerio_if;
   logic [2:0] AD;
   logic [7:0] DI;
   logic [7:0] DO;
   logic       rw;
   logic       cs;
   logic       irq;

   modport slave  (input AD, DI, rw, cs, output DO, irq);
   modport master (output AD, DI, rw, cs, input DO, irq);
endinterface

// File: rtl/timerio_prescaler.sv
// Clock divider: one-cycle tick every div+1 enabled clocks; clr restarts the count.
module timerio_prescaler (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       clr,
   input  logic [7:0] div,
   output logic       tick
);

   logic [7:0] cnt_q, cnt_d;

   // A count already above a newly lowered div runs on to 8'hFF and wraps silently.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q == div) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/timerio.sv
// Interval timer: bus register file, 16-bit down-counter with reload, timeout flag and irq.
module timerio
   import timerio_pkg::*;
#(
   parameter logic [15:0] RESET_RELOAD = 16'hFFFF
) (
   input  logic       clk,
   input  logic       rst,
   timerio_if.slave   bus
);

   ctrl_t       ctrl_q, ctrl_d;
   logic        tof_q, tof_d;
   logic [7:0]  presc_q, presc_d;
   logic [15:0] reload_q, reload_d;
   logic [7:0]  rld_h_q, rld_h_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  lat_q, lat_d;

   logic wr, rd, start, tick;
   logic [7:0] do_v;

   assign wr    = bus.cs & ~bus.rw;
   assign rd    = bus.cs &  bus.rw;
   assign start = wr && (bus.AD == A_CTRL) && bus.DI[CTRL_EN] && !ctrl_q.en;

   timerio_prescaler u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (ctrl_q.en),
      .clr  (start),
      .div  (presc_q),
      .tick (tick)
   );

   always_comb begin
      ctrl_d   = ctrl_q;
      tof_d    = tof_q;
      presc_d  = presc_q;
      reload_d = reload_q;
      rld_h_d  = rld_h_q;
      count_d  = count_q;
      lat_d    = lat_q;

      if (wr) begin
         case (bus.AD)
            A_CTRL:     ctrl_d   = ctrl_t'(bus.DI[2:0]);
            A_STAT:     if (bus.DI[0]) tof_d = 1'b0;
            A_PRESC:    presc_d  = bus.DI;
            A_RELOAD_H: rld_h_d  = bus.DI;
            A_RELOAD_L: reload_d = {rld_h_q, bus.DI};
            default:    ;
         endcase
      end

      if (rd && (bus.AD == A_COUNT_H)) lat_d = count_q[7:0];

      // Expiry is applied after the bus write so a same-cycle STAT clear loses to the set.
      if (start) begin
         count_d = reload_q;
      end else if (tick) begin
         if (count_q != 16'd0) begin
            count_d = count_q - 16'd1;
         end else begin
            tof_d = 1'b1;
            if (ctrl_q.mode) count_d   = reload_q;
            else             ctrl_d.en = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q   <= '0;
         tof_q    <= 1'b0;
         presc_q  <= '0;
         reload_q <= RESET_RELOAD;
         rld_h_q  <= '0;
         count_q  <= '0;
         lat_q    <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         tof_q    <= tof_d;
         presc_q  <= presc_d;
         reload_q <= reload_d;
         rld_h_q  <= rld_h_d;
         count_q  <= count_d;
         lat_q    <= lat_d;
      end
   end

   always_comb begin
      do_v = 8'h00;
      case (bus.AD)
         A_CTRL:     do_v = {5'b0, ctrl_q};
         A_STAT:     do_v = {7'b0, tof_q};
         A_PRESC:    do_v = presc_q;
         A_RELOAD_H: do_v = reload_q[15:8];
         A_RELOAD_L: do_v = reload_q[7:0];
         A_COUNT_H:  do_v = count_q[15:8];
         A_COUNT_L:  do_v = lat_q;
         default:    do_v = 8'h00;
      endcase
   end

   assign bus.DO  = do_v;
   assign bus.irq = tof_q & ctrl_q.ie;

endmodule

// File: tb/tb_timerio.sv
// Self-checking bench for timerio: register table plus timing/corner sequences.
module tb_timerio;

   logic clk;
   logic rst;
   timerio_if bus ();

   timerio #(.RESET_RELOAD(16'hFFFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [7:0] sb_q[$];

   typedef struct {
      bit         is_wr;
      logic [2:0] ad;
      logic [7:0] val;
      string      name;
   } vec_t;
   vec_t vt[$];

   function automatic void add(bit w, logic [2:0] a, logic [7:0] v, string n);
      vec_t e;
      e.is_wr = w; e.ad = a; e.val = v; e.name = n;
      vt.push_back(e);
   endfunction

   task automatic chk(string name, int got, int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wr(logic [2:0] a, logic [7:0] d);
      @(negedge clk);
      bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = a; bus.DI = d;
      @(posedge clk); #1;
      bus.cs = 1'b0; bus.rw = 1'b1;
   endtask

   task automatic rd(logic [2:0] a, logic [7:0] exp, string name);
      logic [7:0] got, e;
      sb_q.push_back(exp);
      @(negedge clk);
      bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = a; bus.DI = 8'h00;
      #1 got = bus.DO;
      e = sb_q.pop_front();
      chk(name, int'(got), int'(e));
      @(posedge clk); #1;
      bus.cs = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_irq(int budget, output int n);
      n = 0;
      while (bus.irq !== 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; bus.cs = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst = 1'b0; bus.cs = 1'b0; bus.rw = 1'b1; bus.AD = 3'd0; bus.DI = 8'h00;

      add(0, 3'd0, 8'h00, "rst_ctrl");
      add(0, 3'd1, 8'h00, "rst_stat");
      add(0, 3'd2, 8'h00, "rst_presc");
      add(0, 3'd3, 8'hFF, "rst_reload_h");
      add(0, 3'd4, 8'hFF, "rst_reload_l");
      add(0, 3'd5, 8'h00, "rst_count_h");
      add(0, 3'd6, 8'h00, "rst_count_l");
      add(0, 3'd7, 8'h00, "rst_addr7");
      add(1, 3'd2, 8'h5A, "");
      add(0, 3'd2, 8'h5A, "presc_rw");
      add(1, 3'd3, 8'h12, "");
      add(0, 3'd3, 8'hFF, "reload_h_buffered");
      add(1, 3'd4, 8'h34, "");
      add(0, 3'd3, 8'h12, "reload_h_commit");
      add(0, 3'd4, 8'h34, "reload_l_commit");
      add(1, 3'd0, 8'h06, "");
      add(0, 3'd0, 8'h06, "ctrl_rw");
      add(1, 3'd7, 8'hAA, "");
      add(0, 3'd7, 8'h00, "addr7_ignored");
      add(1, 3'd6, 8'h77, "");
      add(0, 3'd6, 8'h00, "count_l_wr_ignored");
      add(1, 3'd0, 8'hF8, "");
      add(0, 3'd0, 8'h00, "ctrl_high_bits");
      add(1, 3'd1, 8'hFF, "");
      add(0, 3'd1, 8'h00, "stat_idle");

      do_reset();
      chk("rst_irq", int'(bus.irq), 0);
      foreach (vt[i]) begin
         if (vt[i].is_wr) wr(vt[i].ad, vt[i].val);
         else             rd(vt[i].ad, vt[i].val, vt[i].name);
      end

      // Periodic: 20-clock period, clear then re-expiry.
      do_reset();
      wr(3'd2, 8'h03); wr(3'd3, 8'h00); wr(3'd4, 8'h04);
      wr(3'd0, 8'h07);
      wait_irq(60, n);
      chk("periodic_first", n, 20);
      wr(3'd1, 8'h01);
      chk("irq_cleared", int'(bus.irq), 0);
      wait_irq(60, n);
      chk("periodic_second", n, 19);
      rd(3'd1, 8'h01, "periodic_tof");

      // One-shot.
      do_reset();
      wr(3'd2, 8'h00); wr(3'd3, 8'h00); wr(3'd4, 8'h02);
      wr(3'd0, 8'h05);
      wait_irq(20, n);
      chk("oneshot_delay", n, 3);
      rd(3'd0, 8'h04, "oneshot_en_cleared");
      rd(3'd5, 8'h00, "oneshot_count_h");
      rd(3'd6, 8'h00, "oneshot_count_l");
      wr(3'd1, 8'h01);
      idle(10);
      rd(3'd1, 8'h00, "oneshot_no_reexpiry");

      // Atomic 16-bit count read.
      do_reset();
      wr(3'd2, 8'h00); wr(3'd3, 8'h01); wr(3'd4, 8'h00);
      wr(3'd0, 8'h03);
      rd(3'd5, 8'h01, "atomic_count_h");
      idle(5);
      rd(3'd6, 8'h00, "atomic_count_l_latched");

      // STAT clear racing an expiry.
      do_reset();
      wr(3'd2, 8'h00); wr(3'd3, 8'h00); wr(3'd4, 8'h03);
      wr(3'd0, 8'h07);
      idle(4);
      chk("race_first_irq", int'(bus.irq), 1);
      wr(3'd1, 8'h01);
      chk("race_pre_clear", int'(bus.irq), 0);
      idle(2);
      wr(3'd1, 8'h01);
      chk("race_set_wins_irq", int'(bus.irq), 1);
      rd(3'd1, 8'h01, "race_set_wins_tof");

      // Reload buffering while running.
      do_reset();
      wr(3'd2, 8'h00); wr(3'd3, 8'h00); wr(3'd4, 8'h10);
      wr(3'd0, 8'h07);
      wr(3'd3, 8'h00); wr(3'd4, 8'h03);
      wait_irq(40, n);
      chk("reload_old_period", n, 15);
      wr(3'd1, 8'h01);
      wait_irq(40, n);
      chk("reload_new_period", n, 3);
      wr(3'd3, 8'h55);
      rd(3'd3, 8'h00, "reload_h_only_h");
      rd(3'd4, 8'h03, "reload_h_only_l");

      // IE toggling with TOF held, then reset while irq is high.
      wr(3'd0, 8'h03);
      chk("ie_off_irq", int'(bus.irq), 0);
      rd(3'd1, 8'h01, "ie_off_tof_kept");
      wr(3'd0, 8'h07);
      chk("ie_on_irq", int'(bus.irq), 1);
      do_reset();
      chk("reset_irq", int'(bus.irq), 0);
      rd(3'd0, 8'h00, "reset_ctrl");
      rd(3'd4, 8'hFF, "reset_reload_l");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
